// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the EX-stage divider.
//   WORD_W      architectural word width
//   DIV0_QUO    quotient reported for a divide by zero (all ones)
//   div_state_e divider sequencer states
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] DIV0_QUO = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage : cpu_pkg

// File: rtl/div_sign_fix.sv
// div_sign_fix: combinational conditional two's-complement negate.
// Used to take operand magnitudes and to restore result signs.
//   value   in   WIDTH  operand
//   negate  in   1      1 = return -value, 0 = pass through
//   result  out  WIDTH  value or its two's complement
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    if (negate) begin
      result = (~value) + WIDTH'(1);
    end
  end

endmodule : div_sign_fix

// File: rtl/ex_divider.sv
// ex_divider: multi-cycle restoring radix-2 divider for MIPS DIV/DIVU in EX.
// One quotient bit per cycle; a 100/7 started in cycle 0 reports in cycle
// WIDTH+2. Divide by zero reports in cycle 1.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        DIV/DIVU present in EX (sampled only in IDLE)
//   is_signed    1 = DIV, 0 = DIVU
//   dividend     rs value
//   divisor      rt value
//   flush        abandon the operation in flight
//   stall_req    hold PC, IF/ID and ID/EX (combinational)
//   busy         operation in flight (any non-IDLE state)
//   done         one-cycle result-valid pulse
//   quotient     to LO
//   remainder    to HI
//   div_by_zero  divisor was zero; valid with done
//
// Optional build macro EX_DIV_HILO_EN: adds the architectural HI/LO
// registers (hilo_we, hi_wdata, lo_wdata in; hi_out, lo_out out). The
// divider result written on done takes priority over hilo_we.
module ex_divider
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
`ifdef EX_DIV_HILO_EN
  input  logic             hilo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
`endif
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] quo;      // dividend bits shifting out, quotient bits in
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dbz_reg;

  logic             accept;
  logic             divisor_zero;
  logic             dividend_neg;
  logic             divisor_neg;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] shared_in;
  logic             shared_neg;
  logic [WIDTH-1:0] shared_res;
  logic [WIDTH-1:0] rem_fixed;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  assign accept       = (state == DIV_IDLE) && start && !flush;
  assign divisor_zero = (divisor == '0);
  assign dividend_neg = is_signed && dividend[WIDTH-1];
  assign divisor_neg  = is_signed && divisor[WIDTH-1];

  // Sign handling: the divisor-magnitude negator is idle outside IDLE, so it
  // is reused in FIX to restore the quotient sign.
  assign shared_in  = (state == DIV_FIX) ? quo   : divisor;
  assign shared_neg = (state == DIV_FIX) ? q_neg : divisor_neg;

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_dividend (
    .value  (dividend),
    .negate (dividend_neg),
    .result (dividend_mag)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_shared (
    .value  (shared_in),
    .negate (shared_neg),
    .result (shared_res)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .value  (rem),
    .negate (r_neg),
    .result (rem_fixed)
  );

  // Trial subtraction. rem < dvs, so the shifted remainder fits in WIDTH+1
  // bits and the top bit of the difference is exactly the borrow.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    borrow  = trial[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_req  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      DIV_IDLE: begin
        busy = 1'b0;
        if (accept) begin
          stall_req  = 1'b1;
          state_next = divisor_zero ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        stall_req = 1'b1;
        if (flush) begin
          state_next = DIV_IDLE;
        end else if (cnt == LAST_ITER) begin
          state_next = DIV_FIX;
        end
      end
      DIV_FIX: begin
        stall_req  = 1'b1;
        state_next = flush ? DIV_IDLE : DIV_DONE;
      end
      DIV_DONE: begin
        // start is ignored here: the same instruction is still in EX.
        done       = !flush;
        state_next = DIV_IDLE;
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            if (divisor_zero) begin
              q_reg   <= WIDTH'(DIV0_QUO);
              r_reg   <= dividend;
              dbz_reg <= 1'b1;
            end else begin
              cnt   <= '0;
              rem   <= '0;
              quo   <= dividend_mag;
              dvs   <= shared_res;
              q_neg <= dividend_neg ^ divisor_neg;
              r_neg <= dividend_neg;
            end
          end
        end
        DIV_CALC: begin
          if (!flush) begin
            rem <= borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~borrow};
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV_FIX: begin
          if (!flush) begin
            q_reg   <= shared_res;
            r_reg   <= rem_fixed;
            dbz_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

`ifdef EX_DIV_HILO_EN
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (done) begin
      hi_reg <= r_reg;
      lo_reg <= q_reg;
    end else if (hilo_we) begin
      hi_reg <= hi_wdata;
      lo_reg <= lo_wdata;
    end
  end

  assign hi_out = hi_reg;
  assign lo_out = lo_reg;
`endif

endmodule : ex_divider
